// File: rtl/model_bus_pkg.sv
// Shared definitions for the bit-serial bus packer/deserializer pair:
// FSM state encoding and the stream-position to word-bit mapping.
package model_bus_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  typedef enum logic [1:0] {
    COLLECT = ST_COLLECT,
    DRAIN   = ST_DRAIN,
    HOLD    = ST_HOLD
  } state_e;

  // Word bit written by the k-th bit of a frame (k = 0 is the first bit on the wire).
  function automatic int unsigned word_bit_idx(input int unsigned k,
                                               input int unsigned width,
                                               input bit          msb_first);
    return msb_first ? (width - 1 - k) : k;
  endfunction

endpackage

// File: rtl/model_bus_range_map.sv
// Places an internal [WIDTH-1:0] word onto a descending and an ascending bus that
// share the same logical indices starting at LSB_INDEX (which may be negative).
module model_bus_range_map #(
  parameter int WIDTH     = 5,
  parameter int LSB_INDEX = -2
) (
  input  logic [WIDTH-1:0]                     word_i,
  output logic [WIDTH-1+LSB_INDEX:LSB_INDEX]   desc_o,
  output logic [LSB_INDEX:WIDTH-1+LSB_INDEX]   asc_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_map
    assign desc_o[LSB_INDEX+i] = word_i[i];
    assign asc_o[LSB_INDEX+i]  = word_i[i];
  end

endmodule

// File: rtl/model_bus_deserializer.sv
// Framed 1-bit serial receiver: collects WIDTH bits into a word, rejects short and
// long frames with an error pulse, and holds each good word until it is consumed.
module model_bus_deserializer
  import model_bus_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int LSB_INDEX = -2,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 s_data,
  input  logic                                 s_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [WIDTH-1+LSB_INDEX:LSB_INDEX]   m_desc,
  output logic [LSB_INDEX:WIDTH-1+LSB_INDEX]   m_asc,
  output logic                                 err,
  output logic [CNT_W-1:0]                     frame_cnt
);

  localparam int              BC_W   = $clog2(WIDTH + 1);
  localparam logic [BC_W-1:0] LAST_K = BC_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [BC_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;

  logic               accept;
  int unsigned        bit_idx;
  logic [WIDTH-1:0]   merged;

  assign accept  = s_valid & ready_q;
  assign bit_idx = word_bit_idx(32'(cnt_q), WIDTH, MSB_FIRST);

  // Partial word with the incoming bit already in place; only meaningful in COLLECT.
  for (genvar i = 0; i < WIDTH; i++) begin : g_merge
    assign merged[i] = (bit_idx == i) ? s_data : shreg_q[i];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_K) begin
            cnt_d = '0;
            if (s_last) begin
              word_d  = merged;
              fcnt_d  = fcnt_q + CNT_W'(1);
              state_d = HOLD;
            end else begin
              state_d = DRAIN;
            end
          end else if (s_last) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            shreg_d = merged;
            cnt_d   = cnt_q + BC_W'(1);
          end
        end
      end
      DRAIN: begin
        if (accept && s_last) begin
          err_d   = 1'b1;
          state_d = COLLECT;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase

    // Registered so the handshake cycle out of HOLD never accepts a bit.
    ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign s_ready   = ready_q;
  assign m_valid   = (state_q == HOLD);
  assign err       = err_q;
  assign frame_cnt = fcnt_q;

  model_bus_range_map #(
    .WIDTH     (WIDTH),
    .LSB_INDEX (LSB_INDEX)
  ) u_range_map (
    .word_i (word_q),
    .desc_o (m_desc),
    .asc_o  (m_asc)
  );

endmodule

// File: tb/tb_model_bus_deserializer.sv
// Drives three deserializer variants (MSB-first, LSB-first, 2-bit frame counter)
// in lockstep from one stimulus stream and scores their words against a queue.
module tb_model_bus_deserializer;

  localparam int W = 5;
  localparam int L = -2;

  logic clk = 1'b0;
  logic rst, s_valid, s_data, s_last, m_ready;
  logic rdy_a, rdy_b, rdy_c, val_a, val_b, val_c, err_a, err_b, err_c;
  logic [W-1+L:L] desc_a, desc_b, desc_c;
  logic [L:W-1+L] asc_a, asc_b, asc_c;
  logic [7:0] fc_a, fc_b;
  logic [1:0] fc_c;

  always #5 clk = ~clk;

  model_bus_deserializer #(.WIDTH(W), .LSB_INDEX(L), .MSB_FIRST(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_a), .s_data(s_data), .s_last(s_last),
    .m_valid(val_a), .m_ready(m_ready), .m_desc(desc_a), .m_asc(asc_a), .err(err_a), .frame_cnt(fc_a));

  model_bus_deserializer #(.WIDTH(W), .LSB_INDEX(L), .MSB_FIRST(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_b), .s_data(s_data), .s_last(s_last),
    .m_valid(val_b), .m_ready(m_ready), .m_desc(desc_b), .m_asc(asc_b), .err(err_b), .frame_cnt(fc_b));

  model_bus_deserializer #(.WIDTH(W), .LSB_INDEX(L), .MSB_FIRST(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_c), .s_data(s_data), .s_last(s_last),
    .m_valid(val_c), .m_ready(m_ready), .m_desc(desc_c), .m_asc(asc_c), .err(err_c), .frame_cnt(fc_c));

  typedef struct {
    int         len;
    logic [7:0] bits;  // bits[k] is the k-th bit sent
    bit         gap;
    bit         good;
    logic [4:0] da, aa, db, ab;
  } vec_t;

  typedef struct {
    logic [4:0] da, aa, db, ab;
    logic [7:0] ca;
    logic [7:0] cb;
    logic [1:0] cc;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  exp_t last_good;
  int   good_n;
  int   checks, errors;
  int   nerr_a, nerr_b, nerr_c, nval;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (err_a) nerr_a++;
    if (err_b) nerr_b++;
    if (err_c) nerr_c++;
    if (err_a || val_a) chk("err_valid_overlap", 32'(err_a & val_a), 0);
    if (val_a && m_ready && !rst) begin
      nval++;
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("desc_a", desc_a, e.da);
        chk("asc_a", asc_a, e.aa);
        chk("desc_b", desc_b, e.db);
        chk("asc_b", asc_b, e.ab);
        chk("desc_c", desc_c, e.da);
        chk("asc_c", asc_c, e.aa);
        chk("frame_cnt_a", fc_a, e.ca);
        chk("frame_cnt_b", fc_b, e.cb);
        chk("frame_cnt_c", fc_c, e.cc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the bit was accepted.
  task automatic send_bit(input logic b, input logic last);
    int t;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    t = 0;
    while (rdy_a !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("ready_timeout", t, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] da, input logic [4:0] aa,
                          input logic [4:0] db, input logic [4:0] ab);
    exp_t e;
    good_n++;
    e.da = da; e.aa = aa; e.db = db; e.ab = ab;
    e.ca = 8'(good_n);
    e.cb = 8'(good_n);
    e.cc = 2'(good_n);
    sb.push_back(e);
    last_good = e;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int ea, eb, ec, n0;
    ea = nerr_a; eb = nerr_b; ec = nerr_c; n0 = nval;
    if (v.good) push_exp(v.da, v.aa, v.db, v.ab);
    for (int k = 0; k < v.len; k++) begin
      if (v.gap && k == 2) begin
        repeat (3) @(posedge clk);
        #1;
      end
      send_bit(v.bits[k], k == v.len - 1);
    end
    if (v.good) begin
      chk({tag, "_latency_a"}, 32'(val_a), 1);
      chk({tag, "_latency_b"}, 32'(val_b), 1);
      chk({tag, "_latency_c"}, 32'(val_c), 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_err_pulses_a"}, nerr_a - ea, v.good ? 0 : 1);
    chk({tag, "_err_pulses_b"}, nerr_b - eb, v.good ? 0 : 1);
    chk({tag, "_err_pulses_c"}, nerr_c - ec, v.good ? 0 : 1);
    chk({tag, "_words"}, nval - n0, v.good ? 1 : 0);
    if (!v.good) begin
      chk({tag, "_kept_desc_a"}, desc_a, last_good.da);
      chk({tag, "_kept_asc_a"}, asc_a, last_good.aa);
      chk({tag, "_kept_desc_b"}, desc_b, last_good.db);
      chk({tag, "_kept_cnt_a"}, fc_a, last_good.ca);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v0;
    checks = 0; errors = 0; good_n = 0;
    nerr_a = 0; nerr_b = 0; nerr_c = 0; nval = 0;
    last_good = '{da: 5'h00, aa: 5'h00, db: 5'h00, ab: 5'h00, ca: 8'h00, cb: 8'h00, cc: 2'h0};

    //            len bits   gap good  da     aa     db     ab
    vecs[0] = '{5, 8'h19, 1'b0, 1'b1, 5'h13, 5'h19, 5'h19, 5'h13};
    vecs[1] = '{3, 8'h07, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[2] = '{5, 8'h00, 1'b0, 1'b1, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[3] = '{7, 8'h7F, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[4] = '{5, 8'h0B, 1'b1, 1'b1, 5'h1A, 5'h0B, 5'h0B, 5'h1A};
    vecs[5] = '{5, 8'h1E, 1'b0, 1'b1, 5'h0F, 5'h1E, 5'h1E, 5'h0F};
    vecs[6] = '{5, 8'h01, 1'b0, 1'b1, 5'h10, 5'h01, 5'h01, 5'h10};

    rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy_a), 0);
    chk("rst_valid", 32'(val_a), 0);
    chk("rst_desc", desc_a, 0);
    chk("rst_asc", asc_a, 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_cnt", fc_a, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("vec0_desc_idx2", 32'(desc_a[2]), 1);
        chk("vec0_asc_idx2", 32'(asc_a[2]), 1);
        chk("vec0_asc_idxm2", 32'(asc_a[-2]), 1);
      end
    end

    // HOLD with backpressure: stream 0,1,0,1,1
    m_ready = 1'b0;
    push_exp(5'h0B, 5'h1A, 5'h1A, 5'h0B);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    s_valid = 1'b1;
    s_data  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("hold_ready_a", 32'(rdy_a), 0);
      chk("hold_ready_b", 32'(rdy_b), 0);
      chk("hold_ready_c", 32'(rdy_c), 0);
      chk("hold_valid", 32'(val_a), 1);
      chk("hold_desc", desc_a, 5'h0B);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("release_valid", 32'(val_a), 0);
    chk("release_ready", 32'(rdy_a), 1);
    chk("release_desc_kept", desc_a, 5'h0B);

    // Reset in the middle of a frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    s_valid = 1'b1; s_data = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(rdy_a), 0);
    chk("midrst_valid", 32'(val_a), 0);
    chk("midrst_desc", desc_a, 0);
    chk("midrst_asc", asc_a, 0);
    chk("midrst_desc_b", desc_b, 0);
    chk("midrst_err", 32'(err_a), 0);
    chk("midrst_cnt_a", fc_a, 0);
    chk("midrst_cnt_c", 32'(fc_c), 0);
    rst = 1'b0; s_valid = 1'b0;
    good_n = 0;
    last_good = '{da: 5'h00, aa: 5'h00, db: 5'h00, ab: 5'h00, ca: 8'h00, cb: 8'h00, cc: 2'h0};
    v0 = vecs[0];
    apply_vec(v0, "post_rst");

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
